// File: rtl/serdes_encryptor_scheduler.sv
// Round-robin scheduler that shares one serial encryptor core among NUM_REQ requesters.
// Optional perf counters are enabled with `define SERDES_SCHED_PERF_EN.
module serdes_encryptor_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16,
   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*8-1:0] req_a,
   input  logic [NUM_REQ*8-1:0] req_b,
   output logic [NUM_REQ-1:0]   gnt,
   output logic                 busy,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [7:0]           rsp_data,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 rsp_err,
   output logic                 core_start,
   output logic                 core_a_bit,
   output logic                 core_b_bit,
   input  logic                 core_cipher,
   input  logic                 core_done,
   output logic [CNT_W-1:0]     perf_done_cnt,
   output logic [CNT_W-1:0]     perf_stall_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_FEED, S_WAIT, S_CAPTURE, S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [7:0]      a_q, a_d, b_q, b_d;
   logic [7:0]      data_q, data_d;
   logic            err_q, err_d;
   logic [ID_W-1:0] win_s, idx_s;
   logic            found_s;
   logic [7:0]      a_sel_s, b_sel_s;

   // First set request at or after the pointer, scanning upward with wrap.
   always_comb begin
      win_s   = '0;
      idx_s   = '0;
      found_s = 1'b0;
      a_sel_s = 8'h00;
      b_sel_s = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_s = ID_W'((int'(ptr_q) + i) % NUM_REQ);
         if (!found_s && req[idx_s]) begin
            found_s = 1'b1;
            win_s   = idx_s;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == win_s) begin
            a_sel_s = req_a[i*8 +: 8];
            b_sel_s = req_b[i*8 +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (found_s) begin
               state_d = S_ISSUE;
               id_d    = win_s;
               a_d     = a_sel_s;
               b_d     = b_sel_s;
               ptr_d   = ID_W'((int'(win_s) + 1) % NUM_REQ);
               err_d   = 1'b0;
               cnt_d   = 3'd0;
            end
         end
         S_ISSUE: begin
            state_d = S_FEED;
            cnt_d   = 3'd0;
         end
         S_FEED: begin
            // A done still high from a previous operation is a handshake error.
            if (cnt_q == 3'd0 && core_done) err_d = 1'b1;
            if (cnt_q == 3'd7) begin
               state_d = S_WAIT;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_WAIT: begin
            if (cnt_q == 3'd1) begin
               state_d = S_CAPTURE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_CAPTURE: begin
            data_d = {data_q[6:0], core_cipher};
            if (cnt_q == 3'd7) begin
               if (!core_done) err_d = 1'b1;
               state_d = S_RESP;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         ptr_q   <= '0;
         id_q    <= '0;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         data_q  <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Outputs are decoded straight from registered state.
   always_comb begin
      gnt        = (state_q == S_ISSUE) ? (NUM_REQ'(1) << id_q) : '0;
      core_start = (state_q == S_ISSUE);
      core_a_bit = (state_q == S_FEED) ? a_q[3'd7 - cnt_q] : 1'b0;
      core_b_bit = (state_q == S_FEED) ? b_q[3'd7 - cnt_q] : 1'b0;
      busy       = (state_q != S_IDLE);
      rsp_valid  = (state_q == S_RESP);
      rsp_data   = data_q;
      rsp_id     = id_q;
      rsp_err    = err_q;
   end

`ifdef SERDES_SCHED_PERF_EN
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d, stall_cnt_q, stall_cnt_d;

   // Saturating counters for completed handshakes and back-pressure cycles.
   always_comb begin
      done_cnt_d  = done_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (rsp_valid && rsp_ready && (done_cnt_q != '1)) done_cnt_d = done_cnt_q + CNT_W'(1);
      if (rsp_valid && !rsp_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         done_cnt_q  <= done_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_done_cnt  = done_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`else
   assign perf_done_cnt  = '0;
   assign perf_stall_cnt = '0;
`endif

endmodule
